// File: rtl/test_phase_sequencer.sv
// test_phase_sequencer
//   After a start, runs three back-to-back test phases of programmed lengths,
//   guarded by a watchdog that limits the total number of busy cycles. Phase
//   and status are published as registered outputs for a bench monitor.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous, active-low reset
//   start        level; launches a run when sampled in IDLE, DONE or TMO
//   hold         stalls the phase counter (the watchdog keeps counting)
//   abort        returns to IDLE from any state; highest priority after reset
//   busy         high while in a phase
//   phase        0/1/2 in the matching phase, 3 otherwise
//   phase_start  one-cycle pulse in the first cycle of each phase
//   phase_done   one-cycle pulse in the cycle after a phase's last counted cycle
//   done         high in DONE
//   timeout      high in TMO
//   tick_count   busy cycles of the current/last run, saturating at all-ones
module test_phase_sequencer #(
  parameter int PH0_CYCLES     = 5,
  parameter int PH1_CYCLES     = 10,
  parameter int PH2_CYCLES     = 15,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             hold,
  input  logic             abort,
  output logic             busy,
  output logic [1:0]       phase,
  output logic             phase_start,
  output logic             phase_done,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] tick_count
);

  localparam logic [CNT_W-1:0] PH0_LEN = CNT_W'(PH0_CYCLES);
  localparam logic [CNT_W-1:0] PH1_LEN = CNT_W'(PH1_CYCLES);
  localparam logic [CNT_W-1:0] PH2_LEN = CNT_W'(PH2_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PH0,
    S_PH1,
    S_PH2,
    S_DONE,
    S_TMO
  } state_t;

  state_t           state;
  // Counted (non-held) cycles already completed in the current phase.
  logic [CNT_W-1:0] pcnt;
  // Busy cycles elapsed in this run, including the current one. Never passes
  // TMO_LIM, so it cannot wrap.
  logic [CNT_W-1:0] wdog;

  logic [CNT_W-1:0] cur_len;
  logic             in_phase;
  logic             last_cnt;
  logic             wd_hit;

  function automatic logic [CNT_W-1:0] phase_len(input state_t s);
    case (s)
      S_PH0:   return PH0_LEN;
      S_PH1:   return PH1_LEN;
      S_PH2:   return PH2_LEN;
      default: return PH0_LEN;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    cur_len  = phase_len(state);
    in_phase = (state == S_PH0) || (state == S_PH1) || (state == S_PH2);
    // This cycle is the phase's final counted cycle: leave at the next edge.
    last_cnt = in_phase && !hold && (pcnt == cur_len - 1'b1);
    wd_hit   = in_phase && (wdog == TMO_LIM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pcnt        <= '0;
      wdog        <= '0;
      busy        <= 1'b0;
      phase       <= 2'd3;
      phase_start <= 1'b0;
      phase_done  <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      tick_count  <= '0;
    end else begin
      phase_start <= 1'b0;
      phase_done  <= 1'b0;
      if (abort) begin
        // tick_count is left alone so the aborted run's length stays visible.
        state   <= S_IDLE;
        busy    <= 1'b0;
        phase   <= 2'd3;
        done    <= 1'b0;
        timeout <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_TMO: begin
            if (start) begin
              state       <= S_PH0;
              busy        <= 1'b1;
              phase       <= 2'd0;
              phase_start <= 1'b1;
              done        <= 1'b0;
              timeout     <= 1'b0;
              pcnt        <= '0;
              wdog        <= CNT_W'(1);
              tick_count  <= CNT_W'(1);
            end
          end
          S_PH0, S_PH1: begin
            // Watchdog expiry beats an intermediate phase change.
            if (wd_hit) begin
              state   <= S_TMO;
              busy    <= 1'b0;
              phase   <= 2'd3;
              timeout <= 1'b1;
            end else if (last_cnt) begin
              state       <= (state == S_PH0) ? S_PH1 : S_PH2;
              phase       <= phase + 2'd1;
              phase_start <= 1'b1;
              phase_done  <= 1'b1;
              pcnt        <= '0;
              wdog        <= wdog + 1'b1;
              tick_count  <= sat_inc(tick_count);
            end else begin
              if (!hold) begin
                pcnt <= pcnt + 1'b1;
              end
              wdog       <= wdog + 1'b1;
              tick_count <= sat_inc(tick_count);
            end
          end
          S_PH2: begin
            // Completing the final phase beats a coincident watchdog expiry.
            if (last_cnt) begin
              state      <= S_DONE;
              busy       <= 1'b0;
              phase      <= 2'd3;
              phase_done <= 1'b1;
              done       <= 1'b1;
              pcnt       <= '0;
            end else if (wd_hit) begin
              state   <= S_TMO;
              busy    <= 1'b0;
              phase   <= 2'd3;
              timeout <= 1'b1;
            end else begin
              if (!hold) begin
                pcnt <= pcnt + 1'b1;
              end
              wdog       <= wdog + 1'b1;
              tick_count <= sat_inc(tick_count);
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            phase <= 2'd3;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_test_phase_sequencer.sv
// Bench for test_phase_sequencer. Three instances with watchdog limits 1000,
// 20 and 30 share the same stimulus; a run-level model predicts each one.
module tb_test_phase_sequencer;

  localparam int CW = 16;
  localparam int P0 = 5;
  localparam int P1 = 10;
  localparam int P2 = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic hold  = 1'b0;
  logic abort = 1'b0;

  logic          busy_w [3];
  logic [1:0]    phase_w[3];
  logic          ps_w   [3];
  logic          pd_w   [3];
  logic          done_w [3];
  logic          tmo_w  [3];
  logic [CW-1:0] tick_w [3];

  int checks = 0;
  int errors = 0;
  int c      = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  test_phase_sequencer #(.TIMEOUT_CYCLES(1000), .CNT_W(CW)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .abort(abort),
    .busy(busy_w[0]), .phase(phase_w[0]), .phase_start(ps_w[0]), .phase_done(pd_w[0]),
    .done(done_w[0]), .timeout(tmo_w[0]), .tick_count(tick_w[0]));

  test_phase_sequencer #(.TIMEOUT_CYCLES(20), .CNT_W(CW)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .abort(abort),
    .busy(busy_w[1]), .phase(phase_w[1]), .phase_start(ps_w[1]), .phase_done(pd_w[1]),
    .done(done_w[1]), .timeout(tmo_w[1]), .tick_count(tick_w[1]));

  test_phase_sequencer #(.TIMEOUT_CYCLES(30), .CNT_W(CW)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .abort(abort),
    .busy(busy_w[2]), .phase(phase_w[2]), .phase_start(ps_w[2]), .phase_done(pd_w[2]),
    .done(done_w[2]), .timeout(tmo_w[2]), .tick_count(tick_w[2]));

  // ---------------- run-level model ----------------
  // A run is described by how many counted cycles it has accumulated in total;
  // the phase follows from where that total sits against the cumulative lengths.
  int tlim  [3] = '{1000, 20, 30};
  int m_mode[3];   // 0 idle, 1 running, 2 done, 3 timed out
  int m_cnt [3];   // counted cycles accumulated in this run
  int m_el  [3];   // busy cycles elapsed in this run
  int e_busy[3], e_phase[3], e_ps[3], e_pd[3], e_done[3], e_tmo[3], e_tick[3];

  function automatic int ph_of(input int cnt);
    if (cnt < P0)           return 0;
    if (cnt < P0 + P1)      return 1;
    if (cnt < P0 + P1 + P2) return 2;
    return 3;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_mode[i] = 0; m_cnt[i] = 0; m_el[i] = 0;
        e_busy[i] = 0; e_phase[i] = 3; e_ps[i] = 0; e_pd[i] = 0;
        e_done[i] = 0; e_tmo[i] = 0; e_tick[i] = 0;
      end else begin
        e_ps[i] = 0;
        e_pd[i] = 0;
        if (abort) begin
          m_mode[i] = 0;
          e_busy[i] = 0; e_phase[i] = 3; e_done[i] = 0; e_tmo[i] = 0;
        end else if (m_mode[i] != 1) begin
          if (start) begin
            m_mode[i] = 1; m_cnt[i] = 0; m_el[i] = 1;
            e_busy[i] = 1; e_phase[i] = 0; e_ps[i] = 1;
            e_done[i] = 0; e_tmo[i] = 0; e_tick[i] = 1;
          end
        end else begin
          int old_p, new_c, new_p;
          old_p = ph_of(m_cnt[i]);
          new_c = m_cnt[i] + (hold ? 0 : 1);
          new_p = ph_of(new_c);
          if (new_p == 3) begin
            m_mode[i] = 2;
            e_busy[i] = 0; e_phase[i] = 3; e_pd[i] = 1; e_done[i] = 1;
          end else if (m_el[i] == tlim[i]) begin
            m_mode[i] = 3;
            e_busy[i] = 0; e_phase[i] = 3; e_tmo[i] = 1;
          end else begin
            m_cnt[i] = new_c;
            m_el[i]  = m_el[i] + 1;
            e_tick[i] = (m_el[i] > 65535) ? 65535 : m_el[i];
            e_phase[i] = new_p;
            if (new_p != old_p) begin
              e_ps[i] = 1;
              e_pd[i] = 1;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        logic [22:0] act, exp;
        act = {busy_w[i], phase_w[i], ps_w[i], pd_w[i], done_w[i], tmo_w[i], tick_w[i]};
        exp = {1'(e_busy[i]), 2'(e_phase[i]), 1'(e_ps[i]), 1'(e_pd[i]),
               1'(e_done[i]), 1'(e_tmo[i]), 16'(e_tick[i])};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL model_dut%0d t=%0t cyc=%0d: got %h (busy,phase,ps,pd,done,tmo,tick) want %h",
                   i, $time, c, act, exp);
        end
      end
    end
  end

  // ---------------- directed checks ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0d want %0d", nm, c, act, exp);
    end
  endtask

  task automatic run_to(input int n);
    while (c < n) begin
      @(negedge clk);
      c++;
    end
  endtask

  // Start is high for one cycle (cycle 0); returns in cycle 1.
  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
  endtask

  task automatic pulse_abort();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_busy",  int'(busy_w[0]),  0);
    chk("rst_phase", int'(phase_w[0]), 3);
    chk("rst_tick",  int'(tick_w[0]),  0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: plain run
    launch();
    chk("t1_ps1",   int'(ps_w[0]),   1);
    chk("t1_tick1", int'(tick_w[0]), 1);
    run_to(6);
    chk("t1_pd6",   int'(pd_w[0]) + int'(ps_w[0]), 2);
    chk("t1_ph6",   int'(phase_w[0]), 1);
    run_to(16);
    chk("t1_ps16",  int'(ps_w[0]), 1);
    chk("t1_ph16",  int'(phase_w[0]), 2);
    run_to(30);
    chk("t1_done30", int'(done_w[0]), 0);
    run_to(31);
    chk("t1_pd31",  int'(pd_w[0]),   1);
    chk("t1_done31", int'(done_w[0]), 1);
    run_to(35);
    chk("t1_tick",  int'(tick_w[0]), 30);

    // 2: hold during PH0 (cycles 3-7)
    launch();
    run_to(3);
    hold = 1'b1;
    run_to(8);
    hold = 1'b0;
    run_to(10);
    chk("t2_ph10", int'(phase_w[0]), 0);
    run_to(11);
    chk("t2_ph11", int'(phase_w[0]), 1);
    chk("t2_ps11", int'(ps_w[0]), 1);
    run_to(35);
    chk("t2_done35", int'(done_w[0]), 0);
    run_to(36);
    chk("t2_done36", int'(done_w[0]), 1);
    chk("t2_tick",   int'(tick_w[0]), 35);

    // 3: hold stuck, watchdog 20
    launch();
    hold = 1'b1;
    run_to(20);
    chk("t3_tmo20",  int'(tmo_w[1]),  0);
    chk("t3_busy20", int'(busy_w[1]), 1);
    run_to(21);
    chk("t3_tmo21",   int'(tmo_w[1]),   1);
    chk("t3_phase21", int'(phase_w[1]), 3);
    chk("t3_busy21",  int'(busy_w[1]),  0);
    chk("t3_tick21",  int'(tick_w[1]),  20);
    run_to(40);
    chk("t3_nodone", int'(done_w[1]), 0);
    hold = 1'b0;
    pulse_abort();
    chk("t3_abort_busy", int'(busy_w[0]), 0);

    // 4: completion and watchdog 30 coincide
    launch();
    run_to(30);
    chk("t4_busy30", int'(busy_w[2]), 1);
    run_to(31);
    chk("t4_done31", int'(done_w[2]), 1);
    chk("t4_tmo31",  int'(tmo_w[2]),  0);
    run_to(34);

    // 5: abort in PH1, then restart
    launch();
    run_to(8);
    abort = 1'b1;
    run_to(9);
    abort = 1'b0;
    chk("t5_busy9",  int'(busy_w[0]),  0);
    chk("t5_phase9", int'(phase_w[0]), 3);
    chk("t5_tick9",  int'(tick_w[0]),  8);
    run_to(12);
    start = 1'b1;
    run_to(13);
    start = 1'b0;
    chk("t5_ps13",   int'(ps_w[0]),   1);
    chk("t5_tick13", int'(tick_w[0]), 1);
    run_to(45);

    // start held high: ignored while busy, relaunches from DONE/TMO
    start = 1'b1;
    repeat (75) @(negedge clk);
    start = 1'b0;
    pulse_abort();

    // 6: reset mid-PH2, then a fresh run
    launch();
    run_to(20);
    rst_n = 1'b0;
    run_to(21);
    rst_n = 1'b1;
    chk("t6_rst_phase", int'(phase_w[0]), 3);
    chk("t6_rst_tick",  int'(tick_w[0]),  0);
    chk("t6_rst_busy",  int'(busy_w[0]),  0);
    launch();
    run_to(31);
    chk("t6_done31", int'(done_w[0]), 1);
    chk("t6_tick31", int'(tick_w[0]), 30);
    run_to(33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish want finish before 200000");
    $fatal(1, "simulation time limit");
  end

endmodule
